hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/redirect control for a four-stage
// (IF/ID/EX/MEM) pipeline with precise MEM-stage exceptions and eret.
module hazard_ctrl #(
  parameter logic [29:0] EXC_VECTOR   = 30'h0000_0040,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  input  logic        exc_req,
  input  logic [29:0] exc_pc,
  input  logic        eret,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic        pc_load,
  output logic [29:0] new_pc,
  output logic [29:0] epc,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       exc_take;
  logic       any_stall;

  // Exception entry: MEM must be able to complete before the pipe is drained
  assign exc_take = (state_q == RUN) && exc_req && !mem_busy;

  // Next state, drain counter and all stall/flush/redirect outputs;
  // everything is forced quiet while reset is held
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    pc_load   = 1'b0;
    new_pc    = 30'd0;
    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (exc_take) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            cnt_d     = DRAIN_LOAD;
            state_d   = DRAIN;
          end else if (mem_busy || if_busy) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
          end else if (eret) begin
            pc_load  = 1'b1;
            new_pc   = epc;
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
          end else if (ld_hazard) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            ex_flush = 1'b1;
          end else if (br_taken) begin
            pc_load  = 1'b1;
            new_pc   = br_addr;
            if_flush = 1'b1;
          end
        end
        DRAIN: begin
          if_flush  = 1'b1;
          id_flush  = 1'b1;
          ex_flush  = 1'b1;
          mem_flush = 1'b1;
          if (cnt_q == 3'd0) begin
            state_d = REDIR;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        REDIR: begin
          pc_load  = 1'b1;
          new_pc   = EXC_VECTOR;
          if_flush = 1'b1;
          state_d  = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign any_stall = if_stall | id_stall | ex_stall | mem_stall;

  // State and drain counter registers; reset abandons any exception in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Exception PC capture, only on exception entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc <= 30'd0;
    end else if (exc_take) begin
      epc <= exc_pc;
    end
  end

  // Saturating count of cycles in which any stage was stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (any_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        if_busy;
  logic        mem_busy;
  logic        ld_hazard;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        exc_req;
  logic [29:0] exc_pc;
  logic        eret;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        pc_load;
  logic [29:0] new_pc;
  logic [29:0] epc;
  logic [15:0] stall_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  hazard_ctrl #(
    .EXC_VECTOR  (30'h0000_0040),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_busy  (if_busy),
    .mem_busy (mem_busy),
    .ld_hazard(ld_hazard),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .exc_req  (exc_req),
    .exc_pc   (exc_pc),
    .eret     (eret),
    .if_stall (if_stall),
    .id_stall (id_stall),
    .ex_stall (ex_stall),
    .mem_stall(mem_stall),
    .if_flush (if_flush),
    .id_flush (id_flush),
    .ex_flush (ex_flush),
    .mem_flush(mem_flush),
    .pc_load  (pc_load),
    .new_pc   (new_pc),
    .epc      (epc),
    .stall_cnt(stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_stimulus(input logic ifb, input logic memb, input logic ld,
                                input logic br, input logic [29:0] baddr,
                                input logic exc, input logic [29:0] epc_in,
                                input logic er);
    if_busy   = ifb;
    mem_busy  = memb;
    ld_hazard = ld;
    br_taken  = br;
    br_addr   = baddr;
    exc_req   = exc;
    exc_pc    = epc_in;
    eret      = er;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0);
  endtask

  // Stalls and flushes are ordered {if, id, ex, mem}
  task automatic check_output(input string tag, input logic [3:0] exp_stall,
                              input logic [3:0] exp_flush, input logic exp_load,
                              input logic [29:0] exp_pc);
    logic [38:0] observed;
    logic [38:0] expected;
    observed = {if_stall, id_stall, ex_stall, mem_stall,
                if_flush, id_flush, ex_flush, mem_flush, pc_load, new_pc};
    expected = {exp_stall, exp_flush, exp_load, exp_pc};
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed stall=%b flush=%b pc_load=%b new_pc=%h expected stall=%b flush=%b pc_load=%b new_pc=%h",
             tag, observed[38:35], observed[34:31], observed[30], observed[29:0],
             exp_stall, exp_flush, exp_load, exp_pc);
    end
  endtask

  task automatic check_regs(input string tag, input logic [29:0] exp_epc,
                            input logic [15:0] exp_cnt);
    tests_run++;
    assert ({epc, stall_cnt} === {exp_epc, exp_cnt})
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed epc=%h stall_cnt=%0d expected epc=%h stall_cnt=%0d",
             tag, epc, stall_cnt, exp_epc, exp_cnt);
    end
  endtask

  // Directed sequence: inputs change on the falling edge, checks follow #1 later
  initial begin
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 30'h100, 1'b0, 30'd0, 1'b0);
    #2;
    check_output("reset_outputs", 4'b0000, 4'b0000, 1'b0, 30'd0);
    check_regs("reset_regs", 30'd0, 16'd0);

    @(negedge clk); rst = 1'b1; apply_idle(); #1;
    check_output("run_idle", 4'b0000, 4'b0000, 1'b0, 30'd0);

    // Load-use hazard for one cycle
    @(negedge clk); apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0); #1;
    check_output("ld_hazard", 4'b1100, 4'b0010, 1'b0, 30'd0);
    @(negedge clk); apply_idle(); #1;
    check_output("after_ld_idle", 4'b0000, 4'b0000, 1'b0, 30'd0);
    check_regs("ld_stall_cnt", 30'd0, 16'd1);

    // Taken branch, then branch masked by load hazard
    @(negedge clk); apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 30'h100, 1'b0, 30'd0, 1'b0); #1;
    check_output("branch", 4'b0000, 4'b1000, 1'b1, 30'h100);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 30'h200, 1'b0, 30'd0, 1'b0); #1;
    check_output("ld_over_branch", 4'b1100, 4'b0010, 1'b0, 30'd0);
    @(negedge clk); apply_idle(); #1;
    check_regs("cnt_after_ld_br", 30'd0, 16'd2);

    // Exception held off by mem_busy for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 30'h55, 1'b1, 30'h2A0, 1'b1); #1;
      check_output("exc_mem_busy", 4'b1111, 4'b0000, 1'b0, 30'd0);
    end
    @(negedge clk); apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 1'b1, 30'h2A0, 1'b0); #1;
    check_regs("cnt_after_busy", 30'd0, 16'd5);
    check_output("exc_entry", 4'b0000, 4'b1111, 1'b0, 30'd0);

    // Drain ignores busy, eret and branch
    @(negedge clk); apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1); #1;
    check_output("drain_1", 4'b0000, 4'b1111, 1'b0, 30'd0);
    check_regs("epc_captured", 30'h2A0, 16'd5);
    @(negedge clk); apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 30'h77, 1'b0, 30'd0, 1'b0); #1;
    check_output("drain_2", 4'b0000, 4'b1111, 1'b0, 30'd0);
    @(negedge clk); apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 30'h77, 1'b0, 30'd0, 1'b1); #1;
    check_output("redirect_vector", 4'b0000, 4'b1000, 1'b1, 30'h40);
    @(negedge clk); apply_idle(); #1;
    check_output("back_in_run", 4'b0000, 4'b0000, 1'b0, 30'd0);
    check_regs("regs_after_exc", 30'h2A0, 16'd5);

    // Exception return, then eret masked by an instruction-bus stall
    @(negedge clk); apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 30'h99, 1'b0, 30'd0, 1'b1); #1;
    check_output("eret", 4'b0000, 4'b1110, 1'b1, 30'h2A0);
    @(negedge clk); apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1); #1;
    check_output("eret_if_busy", 4'b1111, 4'b0000, 1'b0, 30'd0);
    @(negedge clk); apply_idle(); #1;
    check_regs("cnt_after_if_busy", 30'h2A0, 16'd6);

    // Exception beats if_busy, then reset while draining
    @(negedge clk); apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 30'd0, 1'b1, 30'h123, 1'b1); #1;
    check_output("exc_over_if_busy", 4'b0000, 4'b1111, 1'b0, 30'd0);
    @(negedge clk); apply_idle(); #1;
    check_output("drain_before_rst", 4'b0000, 4'b1111, 1'b0, 30'd0);
    check_regs("epc_second_exc", 30'h123, 16'd6);
    rst = 1'b0; #1;
    check_output("rst_in_drain", 4'b0000, 4'b0000, 1'b0, 30'd0);
    check_regs("rst_in_drain_regs", 30'd0, 16'd0);
    @(negedge clk); rst = 1'b1; #1;
    check_output("post_rst_0", 4'b0000, 4'b0000, 1'b0, 30'd0);
    @(negedge clk); #1;
    check_output("post_rst_1", 4'b0000, 4'b0000, 1'b0, 30'd0);
    @(negedge clk); #1;
    check_output("post_rst_2", 4'b0000, 4'b0000, 1'b0, 30'd0);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b0, 30'd0, 1'b0); #1;
    check_output("branch_max_addr", 4'b0000, 4'b1000, 1'b1, 30'h3FFF_FFFF);

    @(negedge clk); apply_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
